// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, programmable baud divider
// and a level interrupt raised when the transmitter has fully drained.
module uart_tx_dev #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        txd,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   localparam int         PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

   state_e          state_q, state_d;
   logic [1:0]      ctrl_q, ctrl_d;
   logic [15:0]     div_q, div_d;
   logic            ovf_q, ovf_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW:0]     count_q, count_d;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      shift_q, shift_d;
   logic [15:0]     baud_q, baud_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            txd_q, txd_d;
   logic            irq_q, irq_d;

   logic        wr_data, wr_ctrl, wr_div, wr_status;
   logic [15:0] div_eff;
   logic        bit_done, fifo_empty, fifo_full, busy, can_load, pop, push_ok;
   logic [31:0] count_ext;
   logic        unused_ok;

   assign unused_ok = ^{Addr[29:2], Din[31:16]};

   always_comb begin
      wr_data    = WE && (Addr[1:0] == 2'd0);
      wr_ctrl    = WE && (Addr[1:0] == 2'd1);
      wr_div     = WE && (Addr[1:0] == 2'd2);
      wr_status  = WE && (Addr[1:0] == 2'd3);
      div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
      // Live compare: a DIV lowered below the count ends the bit only after wrap.
      bit_done   = (baud_q == div_eff - 16'd1);
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == DEPTH_C);
      busy       = (state_q != S_IDLE);
      can_load   = ctrl_q[0] && !fifo_empty;
      pop        = can_load && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
      push_ok    = wr_data && (!fifo_full || pop);
   end

   // Register file and FIFO bookkeeping
   always_comb begin
      ctrl_d   = wr_ctrl ? Din[1:0] : ctrl_q;
      div_d    = wr_div ? Din[15:0] : div_q;
      ovf_d    = wr_status ? 1'b0 : (ovf_q || (wr_data && !push_ok));
      wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push_ok && !pop)      count_d = count_q + (PW+1)'(1);
      else if (!push_ok && pop) count_d = count_q - (PW+1)'(1);
      irq_d    = ctrl_q[1] && fifo_empty && !busy;
   end

   // FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (can_load) state_d = S_START;
         S_START: if (bit_done) state_d = S_DATA;
         S_DATA:  if (bit_done && (bit_idx_q == 3'd7)) state_d = S_STOP;
         S_STOP:  if (bit_done) state_d = can_load ? S_START : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: shifter, baud counter and serial output
   always_comb begin
      shift_d   = shift_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      txd_d     = txd_q;
      if (pop) begin
         shift_d   = mem_q[rd_ptr_q];
         baud_d    = 16'd0;
         bit_idx_d = 3'd0;
         txd_d     = 1'b0;
      end else begin
         case (state_q)
            S_START: begin
               baud_d = bit_done ? 16'd0 : baud_q + 16'd1;
               if (bit_done) txd_d = shift_q[0];
            end
            S_DATA: begin
               baud_d = bit_done ? 16'd0 : baud_q + 16'd1;
               if (bit_done) begin
                  if (bit_idx_q == 3'd7) begin
                     txd_d = 1'b1;
                  end else begin
                     shift_d   = {1'b0, shift_q[7:1]};
                     txd_d     = shift_q[1];
                     bit_idx_d = bit_idx_q + 3'd1;
                  end
               end
            end
            S_STOP: begin
               baud_d = bit_done ? 16'd0 : baud_q + 16'd1;
               txd_d  = 1'b1;
            end
            default: txd_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q    <= 2'b00;
         div_q     <= DIV_RESET;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         shift_q   <= 8'h00;
         baud_q    <= 16'd0;
         bit_idx_q <= 3'd0;
         txd_q     <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         div_q     <= div_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         shift_q   <= shift_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         txd_q     <= txd_d;
         irq_q     <= irq_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= Din[7:0];
   end

   always_comb begin
      count_ext = 32'(count_q);
      case (Addr[1:0])
         2'd1:    Dout = {30'd0, ctrl_q};
         2'd2:    Dout = {16'd0, div_q};
         2'd3:    Dout = {25'd0, count_ext[2:0], ovf_q, busy, fifo_full, fifo_empty};
         default: Dout = 32'd0;
      endcase
   end

   assign IRQ       = irq_q;
   assign txd       = txd_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: register-access vector table followed by
// hand-written frame, FIFO-overflow, interrupt and reset sequences.
module tb_uart_tx_dev;

   logic        clk;
   logic        reset;
   logic [29:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        txd;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_dev #(.FIFO_DEPTH(4), .DIV_RESET(16'd434)) dut (
      .clk       (clk),
      .reset     (reset),
      .Addr      (Addr),
      .WE        (WE),
      .Din       (Din),
      .Dout      (Dout),
      .IRQ       (IRQ),
      .txd       (txd),
      .state_dbg (state_dbg)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [1:0]  addr;
      logic        we;
      logic [31:0] din;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      Addr = {28'd0, a};
      Din  = d;
      WE   = 1'b1;
      @(posedge clk);
      #1;
      WE   = 1'b0;
      Din  = 32'd0;
   endtask

   // Called just after the edge that accepted the last write; the first start-bit
   // cycle follows the next edge. Checks every cycle of nb back-to-back frames.
   task automatic check_frames(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input int nb, input int dive, input bit chk_irq,
                               input string tag);
      logic [7:0] bytes [4];
      logic [7:0] cur;
      logic       exp_bit;
      int         f, bp;
      bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
      Addr = 30'd3;
      for (int k = 0; k < 10 * dive * nb; k++) begin
         @(posedge clk);
         @(negedge clk);
         f   = k / (10 * dive);
         bp  = (k % (10 * dive)) / dive;
         cur = bytes[f];
         if (bp == 0)      exp_bit = 1'b0;
         else if (bp == 9) exp_bit = 1'b1;
         else              exp_bit = cur[bp-1];
         check($sformatf("%s txd cyc%0d", tag, k), {31'd0, txd}, {31'd0, exp_bit});
         check($sformatf("%s busy cyc%0d", tag, k), {31'd0, Dout[2]}, 32'd1);
         if (chk_irq && k == 0) check($sformatf("%s irq_drop", tag), {31'd0, IRQ}, 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s idle txd", tag), {31'd0, txd}, 32'd1);
      check($sformatf("%s idle status", tag), Dout, 32'h0000_0001);
   endtask

   initial begin
      reset = 1'b0;
      WE    = 1'b0;
      Addr  = 30'd3;
      Din   = 32'd0;

      vecs[0] = '{2'd3, 1'b0, 32'd0,          32'h0000_0001};
      vecs[1] = '{2'd2, 1'b0, 32'd0,          32'd434};
      vecs[2] = '{2'd1, 1'b0, 32'd0,          32'd0};
      vecs[3] = '{2'd0, 1'b0, 32'd0,          32'd0};
      vecs[4] = '{2'd2, 1'b1, 32'h0001_2345,  32'h0000_2345};
      vecs[5] = '{2'd1, 1'b1, 32'hFFFF_FFFC,  32'd0};
      vecs[6] = '{2'd1, 1'b1, 32'h0000_0002,  32'd2};
      vecs[7] = '{2'd3, 1'b1, 32'hFFFF_FFFF,  32'h0000_0001};
      vecs[8] = '{2'd2, 1'b1, 32'h0000_0004,  32'd4};
      vecs[9] = '{2'd1, 1'b1, 32'h0000_0001,  32'd1};

      // Reset values, sampled while reset is still held low
      repeat (3) @(posedge clk);
      #1;
      check("rst txd", {31'd0, txd}, 32'd1);
      check("rst irq", {31'd0, IRQ}, 32'd0);
      check("rst state", {30'd0, state_dbg}, 32'd0);
      check("rst status", Dout, 32'h0000_0001);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Register access table
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].din);
         Addr = {28'd0, vecs[i].addr};
         @(negedge clk);
         check($sformatf("vec%0d dout", i), Dout, vecs[i].exp_dout);
      end

      // Single frame 0xA5 at DIV=4
      @(posedge clk);
      #1;
      bus_write(2'd0, 32'h0000_00A5);
      check_frames(8'hA5, 8'h00, 8'h00, 8'h00, 1, 4, 1'b0, "a5");

      // FIFO fill, overflow, clear, then back-to-back drain at DIV=2
      bus_write(2'd2, 32'd2);
      bus_write(2'd1, 32'd0);
      bus_write(2'd0, 32'h11);
      bus_write(2'd0, 32'h22);
      bus_write(2'd0, 32'h33);
      bus_write(2'd0, 32'h44);
      Addr = 30'd3;
      @(negedge clk);
      check("fifo full status", Dout, 32'h0000_0042);
      bus_write(2'd0, 32'h55);
      Addr = 30'd3;
      @(negedge clk);
      check("overflow status", Dout, 32'h0000_004A);
      bus_write(2'd3, 32'd0);
      Addr = 30'd3;
      @(negedge clk);
      check("overflow clear", Dout, 32'h0000_0042);
      check("no tx while disabled", {31'd0, txd}, 32'd1);
      @(posedge clk);
      #1;
      bus_write(2'd1, 32'd1);
      check_frames(8'h11, 8'h22, 8'h33, 8'h44, 4, 2, 1'b0, "burst");

      // Interrupt timing at DIV=1
      bus_write(2'd2, 32'd1);
      bus_write(2'd1, 32'd3);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("irq asserted idle", {31'd0, IRQ}, 32'd1);
      @(posedge clk);
      #1;
      bus_write(2'd0, 32'h0F);
      check_frames(8'h0F, 8'h00, 8'h00, 8'h00, 1, 1, 1'b1, "irq");
      check("irq low at idle entry", {31'd0, IRQ}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("irq reasserted", {31'd0, IRQ}, 32'd1);
      @(posedge clk);
      #1;
      bus_write(2'd1, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("irq cleared by irq_en", {31'd0, IRQ}, 32'd0);

      // DIV=0 behaves as one cycle per bit
      @(posedge clk);
      #1;
      bus_write(2'd2, 32'd0);
      Addr = 30'd2;
      @(negedge clk);
      check("div zero readback", Dout, 32'd0);
      @(posedge clk);
      #1;
      bus_write(2'd0, 32'hFF);
      check_frames(8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 1'b0, "div0");

      // Reset during data bit 3 of 0x5A with a second byte queued
      @(posedge clk);
      #1;
      bus_write(2'd2, 32'd8);
      bus_write(2'd0, 32'h5A);
      bus_write(2'd0, 32'h3C);
      Addr = 30'd3;
      repeat (35) @(posedge clk);
      @(negedge clk);
      check("5a bit3 txd", {31'd0, txd}, 32'd1);
      check("5a busy", {31'd0, Dout[2]}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("midrst txd", {31'd0, txd}, 32'd1);
      check("midrst status", Dout, 32'h0000_0001);
      check("midrst state", {30'd0, state_dbg}, 32'd0);
      Addr = 30'd2;
      #1;
      check("midrst div", Dout, 32'd434);
      @(negedge clk);
      reset = 1'b1;
      Addr = 30'd3;
      #1;
      check("post rst status", Dout, 32'h0000_0001);
      bus_write(2'd1, 32'd1);
      Addr = 30'd3;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         check($sformatf("post rst quiet cyc%0d", k), {31'd0, txd}, 32'd1);
      end
      check("post rst still empty", Dout, 32'h0000_0001);

      // Reset during the start bit forces txd high immediately
      @(posedge clk);
      #1;
      bus_write(2'd2, 32'd8);
      bus_write(2'd0, 32'h00);
      @(posedge clk);
      @(negedge clk);
      check("start bit low", {31'd0, txd}, 32'd0);
      #2;
      reset = 1'b0;
      #1;
      check("start rst txd", {31'd0, txd}, 32'd1);
      @(negedge clk);
      reset = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
